// File: rtl/seq_alu.sv
// Registered, handshaked ALU: AND/OR/ADD/SUB/SLT in one cycle, MUL by WIDTH-step shift-add.
// Optional signed/unsigned overflow flag output `ovf` when SEQ_ALU_OVF_EN is defined.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             ex,
   output logic             err
`ifdef SEQ_ALU_OVF_EN
   ,output logic            ovf
`endif
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

`ifdef SEQ_ALU_OVF_EN
   localparam int AW = 2 * WIDTH;
`else
   localparam int AW = WIDTH;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rdy_en_q;
   logic [WIDTH-1:0] z_q, z_d;
   logic             ex_q, ex_d;
   logic             err_q, err_d;
   logic [AW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQ_ALU_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic             slt_s;
   logic [WIDTH-1:0] fast_z_s;
   logic             fast_err_s;
   logic             fast_ovf_s;
   logic             is_mul_s;
   logic             load_s;

   assign sum_s  = a + b;
   assign diff_s = a - b;
   assign slt_s  = $signed(a) < $signed(b);

   // Single-cycle result and op classification for the request on the inputs
   always_comb begin
      fast_z_s   = {WIDTH{1'b0}};
      fast_err_s = 1'b0;
      fast_ovf_s = 1'b0;
      is_mul_s   = 1'b0;
      case (op)
         OP_AND: fast_z_s = a & b;
         OP_OR:  fast_z_s = a | b;
         OP_ADD: begin
            fast_z_s   = sum_s;
            fast_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            fast_z_s   = diff_s;
            fast_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: fast_z_s = {{(WIDTH-1){1'b0}}, slt_s};
         OP_MUL: is_mul_s = 1'b1;
         default: fast_err_s = 1'b1;
      endcase
   end

   // Ready is held low until the first clock after reset releases
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = rdy_en_q;
         S_MUL:   in_ready = 1'b0;
         S_DONE:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   // Next-state, datapath and result register update
   always_comb begin
      state_d  = state_q;
      z_d      = z_q;
      ex_d     = ex_q;
      err_d    = err_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      load_s   = 1'b0;
`ifdef SEQ_ALU_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               load_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               z_d     = acc_q[WIDTH-1:0];
               ex_d    = (acc_q[WIDTH-1:0] == {WIDTH{1'b0}});
               err_d   = 1'b0;
`ifdef SEQ_ALU_OVF_EN
               ovf_d   = |acc_q[AW-1:WIDTH];
`endif
               state_d = S_DONE;
            end else begin
               acc_d    = acc_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  load_s = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Accepting a request: multiply starts iterating, everything else retires next cycle
      case ({load_s, is_mul_s})
         2'b11: begin
            mcand_d  = AW'(a);
            mplier_d = b;
            acc_d    = {AW{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            err_d    = 1'b0;
            state_d  = S_MUL;
         end
         2'b10: begin
            z_d     = fast_z_s;
            ex_d    = (fast_z_s == {WIDTH{1'b0}});
            err_d   = fast_err_s;
`ifdef SEQ_ALU_OVF_EN
            ovf_d   = fast_ovf_s;
`endif
            state_d = S_DONE;
         end
         default: begin
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rdy_en_q <= 1'b0;
         z_q      <= {WIDTH{1'b0}};
         ex_q     <= 1'b0;
         err_q    <= 1'b0;
         mcand_q  <= {AW{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {AW{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
`ifdef SEQ_ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rdy_en_q <= 1'b1;
         z_q      <= z_d;
         ex_q     <= ex_d;
         err_q    <= err_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
`ifdef SEQ_ALU_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign z         = z_q;
   assign ex        = ex_q;
   assign err       = err_q;
`ifdef SEQ_ALU_OVF_EN
   assign ovf       = ovf_q;
`else
   logic unused_ovf_s;
   assign unused_ovf_s = fast_ovf_s;
`endif

endmodule
